// File: rtl/remap_accel_addr_gen.sv
// Raster coordinate walker and linear-address former for remap_accel; feeds a ce-gated DSP multiplier.
// Optional build macro REMAP_ADDR_GEN_OVF_EN enables the sticky address-overflow flag (ovf_err).
module remap_accel_addr_gen #(
  parameter int unsigned DIM_W   = 16,
  parameter int unsigned ADDR_W  = 22,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  rows,
  input  logic [DIM_W-1:0]  cols,
  input  logic [DIM_W-1:0]  stride,
  output logic              busy,
  output logic              done,
  output logic              mul_ce,
  output logic [DIM_W-1:0]  mul_din0,
  output logic [DIM_W-1:0]  mul_din1,
  input  logic [ADDR_W-1:0] mul_dout,
  output logic [ADDR_W-1:0] addr_tdata,
  output logic              addr_tvalid,
  input  logic              addr_tready,
  output logic              addr_tlast,
  output logic              ovf_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state;
  logic [DIM_W-1:0]    rows_q;
  logic [DIM_W-1:0]    cols_q;
  logic [DIM_W-1:0]    col_q;
  logic [MUL_LAT-1:0]  sh_vld;
  logic [MUL_LAT-1:0]  sh_last;
  logic [DIM_W-1:0]    sh_col [MUL_LAT];
  logic                issue;
  logic                col_last;
  logic                row_last;
  logic [ADDR_W-1:0]   addr_next;

  // Backpressure freezes the whole issue/multiply/output pipeline in lockstep.
  assign mul_ce   = !(addr_tvalid && !addr_tready);
  assign issue    = (state == RUN);
  assign col_last = (col_q == cols_q - DIM_W'(1));
  assign row_last = (mul_din0 == rows_q - DIM_W'(1));

`ifdef REMAP_ADDR_GEN_OVF_EN
  localparam int unsigned SUM_W = ADDR_W + 1;
  logic [SUM_W-1:0] sum;

  assign sum       = SUM_W'(mul_dout) + SUM_W'(sh_col[MUL_LAT-1]);
  assign addr_next = sum[ADDR_W-1:0];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ovf_err <= 1'b0;
    end else if (state == IDLE && start) begin
      ovf_err <= 1'b0;
    end else if (mul_ce && sh_vld[MUL_LAT-1] && sum[ADDR_W]) begin
      ovf_err <= 1'b1;
    end
  end
`else
  assign addr_next = mul_dout + ADDR_W'(sh_col[MUL_LAT-1]);
  assign ovf_err   = 1'b0;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rows_q      <= '0;
      cols_q      <= '0;
      col_q       <= '0;
      mul_din0    <= '0;
      mul_din1    <= '0;
      addr_tdata  <= '0;
      addr_tvalid <= 1'b0;
      addr_tlast  <= 1'b0;
      sh_vld      <= '0;
      sh_last     <= '0;
      for (int i = 0; i < MUL_LAT; i++) sh_col[i] <= '0;
    end else begin
      done <= 1'b0;

      // Shadow pipe mirrors the multiplier stages so each product meets its own column.
      if (mul_ce) begin
        sh_vld[0]  <= issue;
        sh_last[0] <= issue && col_last;
        sh_col[0]  <= col_q;
        for (int i = 1; i < MUL_LAT; i++) begin
          sh_vld[i]  <= sh_vld[i-1];
          sh_last[i] <= sh_last[i-1];
          sh_col[i]  <= sh_col[i-1];
        end
        addr_tvalid <= sh_vld[MUL_LAT-1];
        addr_tlast  <= sh_last[MUL_LAT-1];
        addr_tdata  <= addr_next;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (rows == '0 || cols == '0) begin
              done <= 1'b1;
            end else begin
              rows_q   <= rows;
              cols_q   <= cols;
              mul_din1 <= stride;
              mul_din0 <= '0;
              col_q    <= '0;
              busy     <= 1'b1;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          if (mul_ce) begin
            if (col_last) begin
              col_q    <= '0;
              mul_din0 <= mul_din0 + DIM_W'(1);
              if (row_last) state <= DRAIN;
            end else begin
              col_q <= col_q + DIM_W'(1);
            end
          end
        end
        DRAIN: begin
          if (~|sh_vld && (!addr_tvalid || addr_tready)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_remap_accel_addr_gen.sv
// Bench for remap_accel_addr_gen: queue-based address model, 3-stage ce-gated multiplier stub, directed frames.
module tb_remap_accel_addr_gen;
  localparam int unsigned DIM_W   = 16;
  localparam int unsigned ADDR_W  = 22;
  localparam int unsigned MUL_LAT = 3;
`ifdef REMAP_ADDR_GEN_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [ADDR_W-1:0] addr;
    bit                last;
    bit                carry;
  } exp_t;
  typedef logic [31:0] vec_t[$];

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  rows = '0, cols = '0, stride = '0;
  logic              busy, done, mul_ce;
  logic [DIM_W-1:0]  mul_din0, mul_din1;
  logic [ADDR_W-1:0] mul_dout;
  logic [ADDR_W-1:0] addr_tdata;
  logic              addr_tvalid, addr_tlast, ovf_err;
  logic              addr_tready = 1'b1;

  int   n_vec = 0;
  int   n_bad = 0;
  int   acc_cnt = 0;
  int   done_cnt = 0;
  bit   ovf_model = 1'b0;
  bit   stub_en = 1'b0;
  exp_t q[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_last[$];

  remap_accel_addr_gen #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .MUL_LAT(MUL_LAT)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .rows(rows), .cols(cols),
    .stride(stride), .busy(busy), .done(done), .mul_ce(mul_ce), .mul_din0(mul_din0),
    .mul_din1(mul_din1), .mul_dout(mul_dout), .addr_tdata(addr_tdata),
    .addr_tvalid(addr_tvalid), .addr_tready(addr_tready), .addr_tlast(addr_tlast),
    .ovf_err(ovf_err)
  );

  always #5 ap_clk = ~ap_clk;

  // Shared DSP multiplier: 3 ce-gated stages, 22-bit truncated product, optional row-1 stub.
  logic [ADDR_W-1:0] mp [MUL_LAT];
  always @(posedge ap_clk) begin
    if (mul_ce) begin
      mp[0] <= (stub_en && mul_din0 == DIM_W'(1)) ? {ADDR_W{1'b1}}
                                                  : ADDR_W'(32'(mul_din0) * 32'(mul_din1));
      for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
    end
  end
  assign mul_dout = mp[MUL_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Raster order, addr = (row*stride + col) mod 2^22, carry when the true sum reaches 2^22.
  task automatic push_frame(input int r, input int c, input int s, input bit stub);
    for (int rr = 0; rr < r; rr++) begin
      for (int cc = 0; cc < c; cc++) begin
        exp_t   e;
        longint p, sum;
        p       = (stub && rr == 1) ? 64'h3FFFFF : (longint'(rr) * longint'(s)) % (64'd1 << ADDR_W);
        sum     = p + longint'(cc);
        e.addr  = ADDR_W'(sum % (64'd1 << ADDR_W));
        e.carry = (sum >= (64'd1 << ADDR_W));
        e.last  = (cc == c - 1);
        q.push_back(e);
      end
    end
  endtask

  task automatic start_frame(input int r, input int c, input int s, input bit stub);
    @(posedge ap_clk); #1;
    rows   = DIM_W'(r);
    cols   = DIM_W'(c);
    stride = DIM_W'(s);
    start  = 1'b1;
    if (r != 0 && c != 0) push_frame(r, c, s, stub);
    @(posedge ap_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(posedge ap_clk); #1;
      n++;
    end
    check(name, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic check_got(input string name, input vec_t ea, input vec_t el);
    check({name, "_count"}, 32'(got_addr.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < got_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", name, i), got_addr[i], ea[i]);
      check($sformatf("%s_last%0d", name, i), got_last[i], el[i]);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"},  32'(busy), 32'd0);
    check({name, "_done"},  32'(done), 32'd0);
    check({name, "_tvalid"}, 32'(addr_tvalid), 32'd0);
    check({name, "_tlast"}, 32'(addr_tlast), 32'd0);
    check({name, "_tdata"}, 32'(addr_tdata), 32'd0);
    check({name, "_ovf"},   32'(ovf_err), 32'd0);
    check({name, "_din0"},  32'(mul_din0), 32'd0);
    check({name, "_din1"},  32'(mul_din1), 32'd0);
    check({name, "_ce"},    32'(mul_ce), 32'd1);
  endtask

  // Per-cycle compare against the model queue, sampled on the falling edge.
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_data = '0;
  logic              prev_last = 1'b0;
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      q.delete();
      prev_stall = 1'b0;
      ovf_model  = 1'b0;
    end else begin
      check("mul_ce_rule", 32'(mul_ce), 32'(!(addr_tvalid && !addr_tready)));
      if (prev_stall) begin
        check("hold_tvalid", 32'(addr_tvalid), 32'd1);
        check("hold_tdata", 32'(addr_tdata), 32'(prev_data));
        check("hold_tlast", 32'(addr_tlast), 32'(prev_last));
      end
      if (addr_tvalid) begin
        if (q.size() == 0) begin
          check("spurious_tvalid", 32'(addr_tvalid), 32'd0);
        end else begin
          if (q[0].carry && OVF_EN) ovf_model = 1'b1;
          if (addr_tready) begin
            check("addr", 32'(addr_tdata), 32'(q[0].addr));
            check("tlast", 32'(addr_tlast), 32'(q[0].last));
            got_addr.push_back(32'(addr_tdata));
            got_last.push_back(32'(addr_tlast));
            void'(q.pop_front());
            acc_cnt++;
          end
        end
      end
      check("ovf_err", 32'(ovf_err), 32'(ovf_model));
      if (done) begin
        done_cnt++;
        check("busy_at_done", 32'(busy), 32'd0);
      end
      if (start && !busy) ovf_model = 1'b0;
      prev_stall = addr_tvalid && !addr_tready;
      prev_data  = addr_tdata;
      prev_last  = addr_tlast;
    end
  end

  initial begin
    vec_t ea, el;
    int   d0, a0, n;
    bit   found;

    ap_rst_n = 1'b1;
    #1 ap_rst_n = 1'b0;
    #2 check_reset_outputs("por");
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;

    // Basic frame: latency, throughput, tlast, done timing.
    got_addr.delete(); got_last.delete();
    d0 = done_cnt;
    start_frame(2, 3, 4, 1'b0);
    check("busy_after_start", 32'(busy), 32'd1);
    check("din1_stride", 32'(mul_din1), 32'd4);
    for (int k = 1; k <= 4; k++) begin
      @(posedge ap_clk); #1;
      check($sformatf("latency_e%0d", k), 32'(addr_tvalid), 32'(k == 4));
    end
    for (int k = 1; k <= 5; k++) begin
      @(posedge ap_clk); #1;
      check($sformatf("throughput_%0d", k), 32'(addr_tvalid), 32'd1);
    end
    @(posedge ap_clk); #1;
    check("done_after_last", 32'(done), 32'd1);
    check("busy_after_last", 32'(busy), 32'd0);
    @(posedge ap_clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("frame1_done_cnt", 32'(done_cnt - d0), 32'd1);
    ea = '{0, 1, 2, 4, 5, 6};
    el = '{0, 0, 1, 0, 0, 1};
    check_got("frame1", ea, el);

    // Stall while address 1 is presented.
    got_addr.delete(); got_last.delete();
    d0 = done_cnt;
    start_frame(2, 3, 4, 1'b0);
    found = 1'b0;
    n = 0;
    while (!found && n < 20) begin
      @(posedge ap_clk); #1;
      found = addr_tvalid && addr_tdata == ADDR_W'(1);
      n++;
    end
    check("stall_addr1_seen", 32'(found), 32'd1);
    addr_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge ap_clk);
      check("stall_tdata", 32'(addr_tdata), 32'd1);
      check("stall_ce", 32'(mul_ce), 32'd0);
      @(posedge ap_clk); #1;
    end
    addr_tready = 1'b1;
    wait_done("stall_done", d0);
    check_got("stall", ea, el);

    // Zero-size frame.
    d0 = done_cnt;
    a0 = acc_cnt;
    start_frame(0, 7, 3, 1'b0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    @(posedge ap_clk); #1;
    check("zero_done_clr", 32'(done), 32'd0);
    check("zero_busy2", 32'(busy), 32'd0);
    repeat (6) @(posedge ap_clk);
    #1 check("zero_no_addr", 32'(acc_cnt - a0), 32'd0);
    check("zero_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Second start while busy is ignored.
    got_addr.delete(); got_last.delete();
    d0 = done_cnt;
    start_frame(2, 3, 4, 1'b0);
    @(posedge ap_clk); #1;
    rows = 16'd5; cols = 16'd5; stride = 16'd7; start = 1'b1;
    @(posedge ap_clk); #1;
    start = 1'b0;
    wait_done("busy_start_done", d0);
    repeat (12) @(posedge ap_clk);
    #1 check("busy_start_one_done", 32'(done_cnt - d0), 32'd1);
    check("busy_start_idle", 32'(busy), 32'd0);
    check_got("busy_start", ea, el);

    // Reset mid-frame, then a fresh small frame.
    d0 = done_cnt;
    a0 = acc_cnt;
    start_frame(2, 3, 4, 1'b0);
    n = 0;
    while (acc_cnt - a0 < 3 && n < 30) begin
      @(posedge ap_clk); #1;
      n++;
    end
    check("midreset_3acc", 32'(acc_cnt - a0), 32'd3);
    ap_rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    repeat (8) @(posedge ap_clk);
    #1 check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    got_addr.delete(); got_last.delete();
    start_frame(1, 2, 9, 1'b0);
    wait_done("after_reset_done", d0);
    ea = '{0, 1};
    el = '{0, 1};
    check_got("after_reset", ea, el);

    // Address wrap with a stubbed row-1 product.
    got_addr.delete(); got_last.delete();
    d0 = done_cnt;
    stub_en = 1'b1;
    start_frame(2, 2, 16'hFFFF, 1'b1);
    wait_done("ovf_done", d0);
    stub_en = 1'b0;
    ea = '{0, 1, 32'h3FFFFF, 0};
    el = '{0, 1, 0, 1};
    check_got("ovf", ea, el);
    check("ovf_sticky", 32'(ovf_err), 32'(OVF_EN));
    repeat (3) @(posedge ap_clk);
    #1 check("ovf_sticky_later", 32'(ovf_err), 32'(OVF_EN));
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
